// File: rtl/pci_arb_pkg.sv
// Shared constants for the PCI bus arbiter: defaults, wait-counter width and state encoding.
package pci_arb_pkg;

    localparam int unsigned NUM_DEV_DEFAULT      = 4;
    localparam int unsigned IDLE_TIMEOUT_DEFAULT = 16;
    localparam int unsigned WAIT_W               = 5;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_GRANT = 2'd1;
    localparam state_t S_BUSY  = 2'd2;
    localparam state_t S_TURN  = 2'd3;

endpackage

// File: rtl/pci_arbiter_if.sv
// Arbiter-facing PCI sideband signals; all bus signals are active-low except OWNER and BUS_BUSY.
interface pci_arbiter_if
    import pci_arb_pkg::*;
#(
    parameter int unsigned NUM_DEV = NUM_DEV_DEFAULT
);

    logic [NUM_DEV-1:0]         REQ;
    logic                       FRAME;
    logic                       IRDY;
    logic [NUM_DEV-1:0]         GNT;
    logic [$clog2(NUM_DEV)-1:0] OWNER;
    logic                       BUS_BUSY;

    modport master (
        input  REQ,
        input  FRAME,
        input  IRDY,
        output GNT,
        output OWNER,
        output BUS_BUSY
    );

    modport slave (
        output REQ,
        output FRAME,
        output IRDY,
        input  GNT,
        input  OWNER,
        input  BUS_BUSY
    );

endinterface

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first active request searching upward from last+1.
module pci_rr_picker #(
    parameter int unsigned NUM_DEV = 4
) (
    input  logic [NUM_DEV-1:0]         req,
    input  logic [$clog2(NUM_DEV)-1:0] last,
    output logic [$clog2(NUM_DEV)-1:0] winner,
    output logic                       valid
);

    localparam int unsigned IDX_W = $clog2(NUM_DEV);

    always_comb begin
        logic [IDX_W-1:0] idx;
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= NUM_DEV; k++) begin
            idx = IDX_W'((32'(last) + k) % NUM_DEV);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with grant timeout and one-cycle turnaround.
// Define PCI_ARB_PARK_EN to park the bus on the last owner when nobody requests.
module pci_arbiter
    import pci_arb_pkg::*;
#(
    parameter int unsigned NUM_DEV      = NUM_DEV_DEFAULT,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input logic           CLK,
    input logic           RST,
    pci_arbiter_if.master bus
);

    localparam int unsigned        IDX_W     = $clog2(NUM_DEV);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(IDLE_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [NUM_DEV-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic [NUM_DEV-1:0] req_act;
    logic [IDX_W-1:0]   winner;
    logic               win_valid;

    assign req_act = ~bus.REQ;

    pci_rr_picker #(
        .NUM_DEV (NUM_DEV)
    ) u_picker (
        .req    (req_act),
        .last   (last_q),
        .winner (winner),
        .valid  (win_valid)
    );

    function automatic logic [NUM_DEV-1:0] gnt_for(input logic [IDX_W-1:0] idx);
        gnt_for      = '1;
        gnt_for[idx] = 1'b0;
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
`ifdef PCI_ARB_PARK_EN
                // A parked master may start a cycle without requesting first.
                if (gnt_q != '1 && !bus.FRAME) begin
                    state_d = S_BUSY;
                    owner_d = last_q;
                end else if (win_valid) begin
                    state_d = S_GRANT;
                    gnt_d   = gnt_for(winner);
                    owner_d = winner;
                    wait_d  = '0;
                end else begin
                    gnt_d   = gnt_for(last_q);
                    owner_d = last_q;
                end
`else
                if (win_valid) begin
                    state_d = S_GRANT;
                    gnt_d   = gnt_for(winner);
                    owner_d = winner;
                    wait_d  = '0;
                end else begin
                    gnt_d = '1;
                end
`endif
            end
            S_GRANT: begin
                if (!bus.FRAME) begin
                    state_d = S_BUSY;
                end else if (bus.REQ[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    gnt_d   = '1;
                    last_d  = owner_q;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_BUSY: begin
                if (bus.FRAME && bus.IRDY) begin
                    state_d = S_TURN;
                    gnt_d   = '1;
                    last_d  = owner_q;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
                gnt_d   = '1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '1;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_DEV - 1);
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.OWNER    = owner_q;
    assign bus.BUS_BUSY = (state_q == S_BUSY);

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter (NUM_DEV=4, IDLE_TIMEOUT=16) with a round-robin reference model.
module tb_pci_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] prev_gnt = 4'hF;

    pci_arbiter_if #(.NUM_DEV(4)) bus ();

    pci_arbiter #(
        .NUM_DEV      (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Bus-wide grant invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(~bus.GNT) > 1) begin
                errors++;
                $display("FAIL gnt_onehot: GNT=%b has more than one low bit", bus.GNT);
            end
`ifndef PCI_ARB_PARK_EN
            checks++;
            if (prev_gnt != 4'hF && bus.GNT != 4'hF && bus.GNT != prev_gnt) begin
                errors++;
                $display("FAIL gnt_direct_move: GNT %b -> %b without release", prev_gnt, bus.GNT);
            end
`endif
        end
        prev_gnt = bus.GNT;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] req_n);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (last + k) % 4;
            if (req_n[i[1:0]] == 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] gnt_of(input int dev);
        logic [3:0] g;
        g = 4'hF;
        g[dev[1:0]] = 1'b0;
        return g;
    endfunction

    task automatic wait_grant(output int idle_cycles, output bit ok);
        idle_cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.GNT !== 4'hF) begin
                ok = 1'b1;
                break;
            end
            idle_cycles++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.REQ = 4'hF;
        bus.FRAME = 1'b1;
        bus.IRDY = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.GNT !== 4'hF || bus.OWNER !== 2'd0 || bus.BUS_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: GNT=%b OWNER=%0d BUSY=%b expected 1111/0/0",
                     bus.GNT, bus.OWNER, bus.BUS_BUSY);
        end
`ifndef PCI_ARB_PARK_EN
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.GNT !== 4'hF) begin
            errors++;
            $display("FAIL idle_no_req: GNT=%b expected 1111", bus.GNT);
        end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        bus.REQ = 4'b1101;
        tick();
        checks++;
        if (bus.GNT !== 4'b1101 || bus.OWNER !== 2'd1) begin
            errors++;
            $display("FAIL basic_grant: GNT=%b OWNER=%0d expected 1101/1", bus.GNT, bus.OWNER);
        end
        bus.FRAME = 1'b0;
        tick();
        checks++;
        if (bus.BUS_BUSY !== 1'b1 || bus.GNT !== 4'b1101) begin
            errors++;
            $display("FAIL basic_busy: BUSY=%b GNT=%b expected 1/1101", bus.BUS_BUSY, bus.GNT);
        end
        bus.FRAME = 1'b1;
        bus.IRDY = 1'b1;
        bus.REQ = 4'hF;
        tick();
        checks++;
        if (bus.GNT !== 4'hF || bus.BUS_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL basic_turn: GNT=%b BUSY=%b expected 1111/0", bus.GNT, bus.BUS_BUSY);
        end
    endtask

    task automatic test_round_robin();
        int m_last = 3;
        int gap = 0;
        int idle;
        bit ok;
        do_reset();
        bus.REQ = 4'b0000;
        for (int t = 0; t < 5; t++) begin
            int exp;
            exp = rr_pick(m_last, bus.REQ);
            wait_grant(idle, ok);
            gap += idle;
            checks++;
            if (!ok || int'(bus.OWNER) != exp || bus.GNT !== gnt_of(exp)) begin
                errors++;
                $display("FAIL rr_order[%0d]: ok=%0d OWNER=%0d GNT=%b expected %0d/%b",
                         t, ok, bus.OWNER, bus.GNT, exp, gnt_of(exp));
            end
            if (t > 0) begin
                checks++;
                if (gap < 1) begin
                    errors++;
                    $display("FAIL rr_turnaround[%0d]: all-ones cycles=%0d expected >=1", t, gap);
                end
            end
            bus.FRAME = 1'b0;
            tick();
            bus.FRAME = 1'b1;
            bus.IRDY = 1'b1;
            tick();
            m_last = exp;
            gap = (bus.GNT === 4'hF) ? 1 : 0;
        end
        bus.REQ = 4'hF;
    endtask

    task automatic test_timeout();
        int idle;
        bit ok;
        do_reset();
        bus.REQ = 4'b0011;
        wait_grant(idle, ok);
        checks++;
        if (!ok || bus.GNT !== 4'b1011) begin
            errors++;
            $display("FAIL to_grant: GNT=%b expected 1011", bus.GNT);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (bus.GNT !== 4'b1011) begin
                errors++;
                $display("FAIL to_hold[%0d]: GNT=%b expected 1011", k, bus.GNT);
            end
        end
        tick();
        checks++;
        if (bus.GNT !== 4'hF) begin
            errors++;
            $display("FAIL to_release: GNT=%b expected 1111", bus.GNT);
        end
        wait_grant(idle, ok);
        checks++;
        if (!ok || bus.GNT !== 4'b0111 || bus.OWNER !== 2'd3) begin
            errors++;
            $display("FAIL to_next: GNT=%b OWNER=%0d expected 0111/3", bus.GNT, bus.OWNER);
        end
        bus.REQ = 4'hF;
        tick();
    endtask

    task automatic test_reset_busy();
        int idle;
        bit ok;
        do_reset();
        bus.REQ = 4'b0111;
        wait_grant(idle, ok);
        bus.FRAME = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.GNT !== 4'hF || bus.OWNER !== 2'd0 || bus.BUS_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: GNT=%b OWNER=%0d BUSY=%b expected 1111/0/0",
                     bus.GNT, bus.OWNER, bus.BUS_BUSY);
        end
        rst = 1'b0;
        bus.FRAME = 1'b1;
        bus.REQ = 4'b0000;
        wait_grant(idle, ok);
        checks++;
        if (!ok || bus.OWNER !== 2'd0) begin
            errors++;
            $display("FAIL reset_last: OWNER=%0d expected 0", bus.OWNER);
        end
        bus.REQ = 4'hF;
        tick();
    endtask

    task automatic test_frame_priority();
        int idle;
        bit ok;
        do_reset();
        bus.REQ = 4'b1011;
        wait_grant(idle, ok);
        bus.REQ = 4'hF;
        bus.FRAME = 1'b0;
        tick();
        checks++;
        if (bus.BUS_BUSY !== 1'b1 || bus.GNT !== 4'b1011) begin
            errors++;
            $display("FAIL frame_prio: BUSY=%b GNT=%b expected 1/1011", bus.BUS_BUSY, bus.GNT);
        end
        bus.FRAME = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int m_last = 3;
        int idle;
        bit ok;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            logic [3:0] req_v;
            int exp;
            int act;
            req_v = 4'($urandom_range(0, 14));
            bus.REQ = req_v;
            exp = rr_pick(m_last, req_v);
            wait_grant(idle, ok);
            checks++;
            if (!ok || int'(bus.OWNER) != exp || bus.GNT !== gnt_of(exp)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: REQ=%b OWNER=%0d GNT=%b expected %0d/%b",
                         it, req_v, bus.OWNER, bus.GNT, exp, gnt_of(exp));
            end
            act = int'($urandom_range(0, 2));
            if (act == 0) begin
                bus.FRAME = 1'b0;
                tick();
                for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
                    bus.IRDY = 1'($urandom);
                    bus.REQ = 4'($urandom);
                    tick();
                    checks++;
                    if (bus.BUS_BUSY !== 1'b1 || bus.GNT !== gnt_of(exp)
                        || int'(bus.OWNER) != exp) begin
                        errors++;
                        $display("FAIL rand_busy_hold[%0d]: BUSY=%b GNT=%b OWNER=%0d", it,
                                 bus.BUS_BUSY, bus.GNT, bus.OWNER);
                    end
                end
                bus.FRAME = 1'b1;
                bus.IRDY = 1'b1;
                tick();
                checks++;
                if (bus.GNT !== 4'hF || bus.BUS_BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_end[%0d]: GNT=%b BUSY=%b expected 1111/0", it,
                             bus.GNT, bus.BUS_BUSY);
                end
                m_last = exp;
            end else if (act == 1) begin
                req_v[exp[1:0]] = 1'b1;
                bus.REQ = req_v;
                tick();
                checks++;
                if (bus.GNT !== 4'hF) begin
                    errors++;
                    $display("FAIL rand_release[%0d]: GNT=%b expected 1111", it, bus.GNT);
                end
            end else begin
                for (int k = 1; k <= 15; k++) tick();
                checks++;
                if (bus.GNT !== gnt_of(exp)) begin
                    errors++;
                    $display("FAIL rand_pre_timeout[%0d]: GNT=%b expected %b", it, bus.GNT,
                             gnt_of(exp));
                end
                tick();
                checks++;
                if (bus.GNT !== 4'hF) begin
                    errors++;
                    $display("FAIL rand_timeout[%0d]: GNT=%b expected 1111", it, bus.GNT);
                end
                m_last = exp;
            end
        end
        bus.REQ = 4'hF;
        tick();
    endtask

`ifdef PCI_ARB_PARK_EN
    task automatic test_park();
        int idle;
        bit ok;
        do_reset();
        bus.REQ = 4'b1101;
        wait_grant(idle, ok);
        bus.FRAME = 1'b0;
        tick();
        bus.REQ = 4'hF;
        bus.FRAME = 1'b1;
        bus.IRDY = 1'b1;
        tick();
        wait_grant(idle, ok);
        checks++;
        if (!ok || bus.GNT !== 4'b1101) begin
            errors++;
            $display("FAIL park_gnt: GNT=%b expected 1101", bus.GNT);
        end
        bus.REQ = 4'b0111;
        tick();
        checks++;
        if (bus.GNT !== 4'b0111 || bus.OWNER !== 2'd3) begin
            errors++;
            $display("FAIL park_move: GNT=%b OWNER=%0d expected 0111/3", bus.GNT, bus.OWNER);
        end
        bus.REQ = 4'hF;
        tick();
    endtask
`endif

    initial begin
        bus.REQ = 4'hF;
        bus.FRAME = 1'b1;
        bus.IRDY = 1'b1;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_reset_busy();
        test_frame_priority();
        test_random();
`ifdef PCI_ARB_PARK_EN
        test_park();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
